system_bus: RTL and testbench
=============================

Name: system_bus

Overview:
- Single-master, two-slave on-chip bus for the factorial computation system.
- Contains a grant register (arbiter), a fixed-map address decoder, a request-phase path from master to slaves, and a read-data return multiplexer.
- Slave 0 is the system memory; slave 1 is the factorial core register window.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 64, data width.
- S0_LO, 16'h0000, lowest address of slave 0.
- S0_HI, 16'h07FF, highest address of slave 0 (inclusive).
- S1_LO, 16'h7000, lowest address of slave 1.
- S1_HI, 16'h71FF, highest address of slave 1 (inclusive).

Ports:
One clock; reset is asynchronous and active-low. The clock port is clk and the reset port is reset_n.
- clk  in  1  bus clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- m_req  in  1  master bus request.
- m_wr  in  1  master write (1) / read (0).
- m_addr  in  ADDR_W  master address.
- m_dout  in  DATA_W  master write data.
- s0_dout  in  DATA_W  slave 0 read data.
- s1_dout  in  DATA_W  slave 1 read data.
- m_grant  out  1  bus granted to master.
- s0_sel  out  1  slave 0 select.
- s1_sel  out  1  slave 1 select.
- s_wr  out  1  write strobe to slaves.
- s_addr  out  ADDR_W  address to slaves.
- m_din  out  DATA_W  read data returned to master.
- s_din  out  DATA_W  write data to slaves.

Behaviour:
- Arbiter: two states, IDLE and GRANT, held in a flop.
  - IDLE -> GRANT on a clk edge with m_req=1.
  - GRANT -> IDLE on a clk edge with m_req=0.
  - m_grant = (state==GRANT), so it rises and falls one cycle after m_req.
- Request path (combinational) while m_grant=1: s_wr=m_wr, s_addr=m_addr, s_din=m_dout.
- While m_grant=0: s_wr=0, s_addr=0, s_din=0.
- Decoder (combinational), both selects gated by m_grant:
  - s0_sel=1 iff S0_LO<=m_addr<=S0_HI.
  - s1_sel=1 iff S1_LO<=m_addr<=S1_HI.
  - Address ranges must not overlap; at most one select is high.
  - Unmapped address: both selects 0, and s_wr is still driven, but no slave acts on it.
- Read return:
  - A 2-bit register rsel captures {s1_sel,s0_sel} every clk edge.
  - m_din = s0_dout if rsel[0]; s1_dout if rsel[1]; otherwise 0.
  - Read data therefore returns one cycle after the address phase, matching synchronous slaves.
  - rsel is captured on writes as well, so m_din may show slave data after a write; the master ignores it.
- Reset (asynchronous, any time including mid-transfer):
  - state=IDLE, rsel=0.
  - All outputs are 0 immediately: m_grant, s0_sel, s1_sel, s_wr, s_addr, s_din, m_din.
- After reset release, the first grant requires a clk edge with m_req=1.
- Address or m_wr changes while granted take effect combinationally in the same cycle; no re-arbitration is needed.

Optional Feature:
- Macro BUS_UNMAPPED_PATTERN_EN.
- Defined: when rsel==0 and the previous cycle was a granted access (tracked by a 1-bit registered grant flag), m_din returns 64'hDEADBEEF_DEADBEEF to flag an access to an unmapped address.
- Undefined: m_din is 0 whenever rsel==0.

Decomposition:
- Shared package system_bus_pkg holds:
  - ADDR_W and DATA_W constants.
  - The slave map constants S0_LO, S0_HI, S1_LO and S1_HI.
  - The arbiter state typedef (IDLE, GRANT).
  - The unmapped-read pattern constant.
- One sub-module, bus_addr_decoder: purely combinational; maps address plus grant to s0_sel/s1_sel.
- Arbiter and read mux stay in the top level.

Test Plan:
1. Reset: reset_n=0 with m_req=1 and s0_dout=64'hFF, s1_dout=64'hFFF -> every output 0; no grant until an edge after reset_n=1.
2. Write to slave 0: m_req=1, m_wr=1, m_addr=16'h0010, m_dout=64'hAABBCCDDEEFF0011 -> after one edge:
   - m_grant=1, s0_sel=1, s1_sel=0, s_wr=1;
   - s_addr=16'h0010, s_din=64'hAABBCCDDEEFF0011.
3. Read from slave 1 while granted: m_addr=16'h7010, m_wr=0 -> immediately s1_sel=1, s0_sel=0, s_wr=0; m_din=64'hFFF from the next edge.
4. Read from slave 0: m_addr=16'h07FF, m_wr=0 -> s0_sel=1; next cycle m_din=64'hFF. Then m_addr=16'h0800 -> both selects 0; next cycle m_din=0, or 64'hDEADBEEF_DEADBEEF with BUS_UNMAPPED_PATTERN_EN.
5. Release: m_req=0 -> after one edge m_grant=0, selects 0, s_addr=0, s_din=0; one edge later m_din=0.
6. Mid-transfer reset: pulse reset_n low between edges during a granted read of 16'h7010 -> m_grant, s1_sel and m_din drop to 0 asynchronously, without waiting for clk.

Source files
------------

// File: rtl/system_bus_pkg.sv
// Shared constants and types for the single-master, two-slave system bus.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package system_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 64;

  // Slave 0: system memory. Slave 1: factorial core register window.
  localparam logic [ADDR_W-1:0] S0_LO = 16'h0000;
  localparam logic [ADDR_W-1:0] S0_HI = 16'h07FF;
  localparam logic [ADDR_W-1:0] S1_LO = 16'h7000;
  localparam logic [ADDR_W-1:0] S1_HI = 16'h71FF;

  // Returned on a read that hit no slave, when that flagging is built in.
  localparam logic [DATA_W-1:0] UNMAPPED_PAT = 64'hDEADBEEF_DEADBEEF;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } bus_state_t;

  // Inclusive address window test.
  function automatic logic in_range(input logic [ADDR_W-1:0] a,
                                    input logic [ADDR_W-1:0] lo,
                                    input logic [ADDR_W-1:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// Fixed-map address decoder: turns a granted address into one-hot slave selects.
// Latency: purely combinational, zero cycles.
// Backpressure: none; both selects are held low while the bus is not granted.
module bus_addr_decoder
  import system_bus_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  input  logic              grant,
  output logic              s0_sel,
  output logic              s1_sel
);

  // The two windows are disjoint, so at most one select can be high.
  assign s0_sel = grant & in_range(addr, S0_LO, S0_HI);
  assign s1_sel = grant & in_range(addr, S1_LO, S1_HI);

endmodule

// File: rtl/system_bus.sv
// Single-master, two-slave bus: grant register, address decode, request path, read-return mux.
// Latency: grant follows m_req by one edge; request path is combinational; read data returns one edge after the address phase.
// Backpressure: none; the master simply holds m_req. Optional BUS_UNMAPPED_PATTERN_EN returns a marker word after an unmapped granted access.
module system_bus
  import system_bus_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m_req,
  input  logic              m_wr,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_dout,
  input  logic [DATA_W-1:0] s0_dout,
  input  logic [DATA_W-1:0] s1_dout,
  output logic              m_grant,
  output logic              s0_sel,
  output logic              s1_sel,
  output logic              s_wr,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] m_din,
  output logic [DATA_W-1:0] s_din
);

  bus_state_t state, state_nxt;
  logic [1:0] rsel;

  // Arbiter state register; reset drops the grant without waiting for clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Arbiter next state: grant follows the request with one edge of delay.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (m_req)  state_nxt = GRANT;
      GRANT:   if (!m_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign m_grant = (state == GRANT);

  bus_addr_decoder u_dec (
    .addr   (m_addr),
    .grant  (m_grant),
    .s0_sel (s0_sel),
    .s1_sel (s1_sel)
  );

  // Request path is forced to zero whenever the master does not own the bus.
  assign s_wr   = m_grant & m_wr;
  assign s_addr = m_grant ? m_addr : '0;
  assign s_din  = m_grant ? m_dout : '0;

  // Remember which slave was addressed so its synchronous read data can be steered back.
  // Captured on writes too; the master ignores m_din in that case.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rsel <= 2'b00;
    else          rsel <= {s1_sel, s0_sel};
  end

`ifdef BUS_UNMAPPED_PATTERN_EN
  logic gnt_q;

  // Marks that the previous cycle was a granted access, to tell an unmapped hit from an idle bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) gnt_q <= 1'b0;
    else          gnt_q <= m_grant;
  end

  // Read-return mux with unmapped-access marker.
  always_comb begin
    m_din = '0;
    if (rsel[0])      m_din = s0_dout;
    else if (rsel[1]) m_din = s1_dout;
    else if (gnt_q)   m_din = UNMAPPED_PAT;
  end
`else
  // Read-return mux; nothing selected reads as zero.
  always_comb begin
    m_din = '0;
    if (rsel[0])      m_din = s0_dout;
    else if (rsel[1]) m_din = s1_dout;
  end
`endif

endmodule

// File: tb/tb_system_bus.sv
// Randomized self-checking bench for system_bus against a transaction-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_system_bus;
  import system_bus_pkg::*;

`ifdef BUS_UNMAPPED_PATTERN_EN
  localparam bit PAT_EN = 1'b1;
`else
  localparam bit PAT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              m_req = 1'b0;
  logic              m_wr = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_dout = '0;
  logic [DATA_W-1:0] s0_dout = '0;
  logic [DATA_W-1:0] s1_dout = '0;
  logic              m_grant, s0_sel, s1_sel, s_wr;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] m_din, s_din;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bus, which slave the last cycle addressed
  // (0 none, 1 memory, 2 factorial core) and whether that cycle was granted.
  bit granted  = 1'b0;
  int last_slv = 0;
  bit last_gnt = 1'b0;

  system_bus dut (
    .clk     (clk),
    .reset_n (reset_n),
    .m_req   (m_req),
    .m_wr    (m_wr),
    .m_addr  (m_addr),
    .m_dout  (m_dout),
    .s0_dout (s0_dout),
    .s1_dout (s1_dout),
    .m_grant (m_grant),
    .s0_sel  (s0_sel),
    .s1_sel  (s1_sel),
    .s_wr    (s_wr),
    .s_addr  (s_addr),
    .m_din   (m_din),
    .s_din   (s_din)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int slave_of(input logic [15:0] a);
    if (a <= 16'h07FF) return 1;
    if (a >= 16'h7000 && a <= 16'h71FF) return 2;
    return 0;
  endfunction

  task automatic check_all(input string tag);
    logic [63:0] exp_din;
    int slv;
    slv = slave_of(m_addr);
    if (last_slv == 1)      exp_din = s0_dout;
    else if (last_slv == 2) exp_din = s1_dout;
    else if (PAT_EN && last_gnt) exp_din = 64'hDEADBEEF_DEADBEEF;
    else                    exp_din = 64'h0;
    check({tag, ".m_grant"}, 64'(m_grant), 64'(granted));
    check({tag, ".s0_sel"},  64'(s0_sel),  64'(granted && slv == 1));
    check({tag, ".s1_sel"},  64'(s1_sel),  64'(granted && slv == 2));
    check({tag, ".s_wr"},    64'(s_wr),    64'(granted && m_wr));
    check({tag, ".s_addr"},  64'(s_addr),  granted ? 64'(m_addr) : 64'h0);
    check({tag, ".s_din"},   s_din,        granted ? m_dout : 64'h0);
    check({tag, ".m_din"},   m_din,        exp_din);
  endtask

  task automatic model_reset();
    granted  = 1'b0;
    last_slv = 0;
    last_gnt = 1'b0;
  endtask

  // One clock edge; the model advances using the inputs held across the edge.
  task automatic tick();
    @(posedge clk);
    if (!reset_n) model_reset();
    else begin
      last_slv = granted ? slave_of(m_addr) : 0;
      last_gnt = granted;
      granted  = m_req;
    end
    #1;
  endtask

  task automatic apply(input bit req, input bit wr, input logic [15:0] addr,
                       input logic [63:0] dout, input logic [63:0] d0, input logic [63:0] d1);
    m_req = req; m_wr = wr; m_addr = addr; m_dout = dout; s0_dout = d0; s1_dout = d1;
    #1;
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 9))
      0: return 16'h0000;
      1: return 16'h07FF;
      2: return 16'h0800;
      3: return 16'h6FFF;
      4: return 16'h7000;
      5: return 16'h71FF;
      6: return 16'h7200;
      7: return 16'(16'h7000 + $urandom_range(0, 16'h1FF));
      8: return 16'($urandom_range(0, 16'h7FF));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    // Reset held with a pending request: everything stays low.
    apply(1'b1, 1'b0, 16'h0010, 64'h0, 64'hFF, 64'hFFF);
    tick();
    tick();
    check_all("reset");
    check("reset.m_din_const", m_din, 64'h0);
    #2 reset_n = 1'b1;
    #1 check("post_release.m_grant", 64'(m_grant), 64'h0);
    check_all("post_release");

    // Write to memory.
    apply(1'b1, 1'b1, 16'h0010, 64'hAABBCCDDEEFF0011, 64'hFF, 64'hFFF);
    tick();
    check_all("wr_s0");
    check("wr_s0.s_din_const", s_din, 64'hAABBCCDDEEFF0011);
    check("wr_s0.s0_sel_const", 64'(s0_sel), 64'h1);

    // Read factorial core while granted, then memory top, then just past it.
    apply(1'b1, 1'b0, 16'h7010, 64'h0, 64'hFF, 64'hFFF);
    check_all("rd_s1_addr");
    tick();
    check_all("rd_s1_data");
    check("rd_s1.m_din_const", m_din, 64'hFFF);
    apply(1'b1, 1'b0, 16'h07FF, 64'h0, 64'hFF, 64'hFFF);
    tick();
    check("rd_s0.m_din_const", m_din, 64'hFF);
    apply(1'b1, 1'b0, 16'h0800, 64'h0, 64'hFF, 64'hFFF);
    check_all("unmapped_addr");
    tick();
    check_all("unmapped_data");
    check("unmapped.m_din_const", m_din, PAT_EN ? 64'hDEADBEEF_DEADBEEF : 64'h0);

    // Release.
    apply(1'b0, 1'b0, 16'h0010, 64'h1234, 64'hFF, 64'hFFF);
    tick();
    check_all("release1");
    tick();
    check_all("release2");
    check("release.m_din_const", m_din, 64'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 3) != 0, 1'($urandom), pick_addr(),
            {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      check_all("rnd_comb");
      tick();
      check_all("rnd_edge");
    end

    // Asynchronous reset during a granted factorial-core read.
    apply(1'b1, 1'b0, 16'h7010, 64'h0, 64'h55, 64'h77);
    tick();
    tick();
    check("midrst.pre_m_din", m_din, 64'h77);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("midrst.m_grant", 64'(m_grant), 64'h0);
    check("midrst.s1_sel", 64'(s1_sel), 64'h0);
    check("midrst.m_din", m_din, 64'h0);
    check_all("midrst");
    #3 reset_n = 1'b1;
    tick();
    check_all("midrst_regrant");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
